// File: rtl/cpu_pkg.sv
// Types and constants shared by the store drain buffer: store-type encoding,
// the inactive byte-write-enable pattern and the drain FSM state set.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_ILL = 2'b00,
    ST_SB  = 2'b01,
    ST_SH  = 2'b10,
    ST_SW  = 2'b11
  } st_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_e;

  localparam logic [3:0] WEB_NONE = 4'hF;

endpackage

// File: rtl/store_lane_fmt.sv
// Places right-aligned store data into its byte lanes and builds the matching
// active-low byte write enables; flags illegal types and misaligned offsets.
module store_lane_fmt
  import cpu_pkg::*;
(
  input  logic [1:0]  i_type,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  output logic [3:0]  o_web,
  output logic [31:0] o_di,
  output logic        o_illegal
);

  always_comb begin
    o_web     = WEB_NONE;
    o_di      = 32'h0;
    o_illegal = 1'b1;
    case (i_type)
      ST_SB: begin
        o_illegal = 1'b0;
        o_web     = ~(4'b0001 << i_off);
        o_di      = {24'h0, i_data[7:0]} << {i_off, 3'b000};
      end
      ST_SH: begin
        if (!i_off[0]) begin
          o_illegal = 1'b0;
          o_web     = i_off[1] ? 4'b0011 : 4'b1100;
          o_di      = {16'h0, i_data[15:0]} << {i_off[1], 4'b0000};
        end
      end
      ST_SW: begin
        if (i_off == 2'b00) begin
          o_illegal = 1'b0;
          o_web     = 4'b0000;
          o_di      = i_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_drain_buffer.sv
// Small in-order store FIFO between the MEM stage and the data memory; drains
// one entry per grant and reports loads that hit a pending store word.
module store_drain_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [1:0]    st_type,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  output logic          st_misalign,
  input  logic          ld_chk_valid,
  input  logic [31:0]   ld_chk_addr,
  output logic          ld_conflict,
  output logic          dm_req,
  input  logic          dm_gnt,
  output logic          DM_CEB,
  output logic [3:0]    DM_WEB,
  output logic [AW-1:0] DM_A,
  output logic [31:0]   DM_DI,
  output logic          busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [3:0]    r_web   [DEPTH];
  logic [31:0]   r_di    [DEPTH];
  logic [29:0]   r_waddr [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count, w_count_next;
  logic          r_misalign;
  drain_state_e  r_state, w_state_next;

  logic [3:0]    w_web;
  logic [31:0]   w_di;
  logic          w_illegal;
  logic          w_accept, w_push, w_pop, w_conflict;
  logic [PW-1:0] w_idx;

  store_lane_fmt u_fmt (
    .i_type    (st_type),
    .i_off     (st_addr[1:0]),
    .i_data    (st_data),
    .o_web     (w_web),
    .o_di      (w_di),
    .o_illegal (w_illegal)
  );

  assign st_ready    = (r_count < FULL);
  assign w_accept    = st_valid && st_ready;
  assign w_push      = w_accept && !w_illegal;
  assign w_pop       = (r_state == REQ) && dm_gnt;
  assign st_misalign = r_misalign;
  assign busy        = (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (PW+1)'(1);
      2'b01:   w_count_next = r_count - (PW+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept && w_illegal;
      r_count    <= w_count_next;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Entry storage needs no reset: only slots counted as valid are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_web[r_wptr]   <= w_web;
      r_di[r_wptr]    <= w_di;
      r_waddr[r_wptr] <= st_addr[31:2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_count_next != '0) w_state_next = REQ;
      REQ:     if (w_count_next == '0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    dm_req = 1'b0;
    DM_WEB = WEB_NONE;
    DM_A   = '0;
    DM_DI  = 32'h0;
    if (r_state == REQ) begin
      dm_req = 1'b1;
      DM_WEB = r_web[r_rptr];
      DM_A   = r_waddr[r_rptr][AW-1:0];
      DM_DI  = r_di[r_rptr];
    end
  end

  assign DM_CEB = !dm_req;

  // Walk from the head so only occupied slots take part in the match.
  always_comb begin
    w_conflict = 1'b0;
    w_idx      = r_rptr;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr + PW'(k);
      if (((PW+1)'(k) < r_count) && (r_waddr[w_idx] == ld_chk_addr[31:2]))
        w_conflict = 1'b1;
    end
  end

  assign ld_conflict = ld_chk_valid && w_conflict;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: lane formatting, misalign drop,
// back-pressure and in-order drain, load conflict and mid-drain reset.
module tb_store_drain_buffer;

  logic        clk, rst;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_addr, st_data;
  logic        st_ready, st_misalign;
  logic        ld_chk_valid;
  logic [31:0] ld_chk_addr;
  logic        ld_conflict;
  logic        dm_req, dm_gnt, DM_CEB;
  logic [3:0]  DM_WEB;
  logic [13:0] DM_A;
  logic [31:0] DM_DI;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] SB = 2'b01, SH = 2'b10, SW = 2'b11;

  store_drain_buffer #(.DEPTH(2), .AW(14)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_misalign(st_misalign),
    .ld_chk_valid(ld_chk_valid), .ld_chk_addr(ld_chk_addr), .ld_conflict(ld_conflict),
    .dm_req(dm_req), .dm_gnt(dm_gnt), .DM_CEB(DM_CEB), .DM_WEB(DM_WEB),
    .DM_A(DM_A), .DM_DI(DM_DI), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] t,
                               input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dm_gnt = 1'b0;
    ld_chk_valid = 1'b0;
    ld_chk_addr = 32'h0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    #12;
    checkOutput("rst_ready",    32'(st_ready),    32'd1);
    checkOutput("rst_misalign", 32'(st_misalign), 32'd0);
    checkOutput("rst_ldconf",   32'(ld_conflict), 32'd0);
    checkOutput("rst_req",      32'(dm_req),      32'd0);
    checkOutput("rst_ceb",      32'(DM_CEB),      32'd1);
    checkOutput("rst_web",      32'(DM_WEB),      32'hF);
    checkOutput("rst_a",        32'(DM_A),        32'h0);
    checkOutput("rst_di",       32'(DM_DI),       32'h0);
    checkOutput("rst_busy",     32'(busy),        32'd0);
    rst = 1'b0;
    nextCycle();

    // SB at byte 3 of word 0x400
    dm_gnt = 1'b1;
    applyStimulus(1'b1, SB, 32'h0000_1003, 32'h0000_00AB);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("sb_ceb", 32'(DM_CEB), 32'd0);
    checkOutput("sb_web", 32'(DM_WEB), 32'h7);
    checkOutput("sb_di",  DM_DI,       32'hAB00_0000);
    checkOutput("sb_a",   32'(DM_A),   32'h400);
    nextCycle();
    checkOutput("sb_idle_req",  32'(dm_req), 32'd0);
    checkOutput("sb_idle_busy", 32'(busy),   32'd0);

    // SH upper half, then misaligned SW
    applyStimulus(1'b1, SH, 32'h0000_2002, 32'h0000_1234);
    nextCycle();
    applyStimulus(1'b1, SW, 32'h0000_2002, 32'hCAFE_F00D);
    checkOutput("sh_web", 32'(DM_WEB), 32'h3);
    checkOutput("sh_di",  DM_DI,       32'h1234_0000);
    checkOutput("sh_a",   32'(DM_A),   32'h800);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("mis_pulse", 32'(st_misalign), 32'd1);
    checkOutput("mis_busy",  32'(busy),        32'd0);
    checkOutput("mis_req",   32'(dm_req),      32'd0);
    checkOutput("mis_ready", 32'(st_ready),    32'd1);
    nextCycle();
    checkOutput("mis_clear", 32'(st_misalign), 32'd0);

    // back-pressure with DEPTH=2, then in-order drain
    dm_gnt = 1'b0;
    applyStimulus(1'b1, SW, 32'h10, 32'h1111_1111);
    nextCycle();
    checkOutput("bp1_a",     32'(DM_A),     32'h4);
    checkOutput("bp1_ready", 32'(st_ready), 32'd1);
    applyStimulus(1'b1, SW, 32'h14, 32'h2222_2222);
    nextCycle();
    checkOutput("bp2_ready", 32'(st_ready), 32'd0);
    applyStimulus(1'b1, SW, 32'h18, 32'h3333_3333);
    nextCycle();
    checkOutput("bp3_ready", 32'(st_ready), 32'd0);
    checkOutput("bp3_a",     32'(DM_A),     32'h4);
    checkOutput("bp3_di",    DM_DI,         32'h1111_1111);
    checkOutput("bp3_web",   32'(DM_WEB),   32'h0);
    dm_gnt = 1'b1;
    nextCycle();
    checkOutput("dr1_a",     32'(DM_A),     32'h5);
    checkOutput("dr1_di",    DM_DI,         32'h2222_2222);
    checkOutput("dr1_ready", 32'(st_ready), 32'd1);
    checkOutput("dr1_busy",  32'(busy),     32'd1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("dr2_a",  32'(DM_A), 32'h6);
    checkOutput("dr2_di", DM_DI,     32'h3333_3333);
    nextCycle();
    checkOutput("dr3_req",  32'(dm_req), 32'd0);
    checkOutput("dr3_busy", 32'(busy),   32'd0);

    // load conflict against a buffered word
    dm_gnt = 1'b0;
    applyStimulus(1'b1, SW, 32'h100, 32'h0000_0055);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    ld_chk_valid = 1'b1;
    ld_chk_addr  = 32'h102;
    #1 checkOutput("ld_hit", 32'(ld_conflict), 32'd1);
    ld_chk_addr = 32'h104;
    #1 checkOutput("ld_miss", 32'(ld_conflict), 32'd0);
    ld_chk_addr = 32'h102;
    ld_chk_valid = 1'b0;
    #1 checkOutput("ld_novalid", 32'(ld_conflict), 32'd0);
    dm_gnt = 1'b1;
    nextCycle();
    ld_chk_valid = 1'b1;
    #1 checkOutput("ld_after_drain", 32'(ld_conflict), 32'd0);

    // incoming store is not yet visible to the load check
    applyStimulus(1'b1, SW, 32'h200, 32'h0000_0077);
    ld_chk_addr = 32'h200;
    #1 checkOutput("ld_incoming", 32'(ld_conflict), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    #1 checkOutput("ld_buffered", 32'(ld_conflict), 32'd1);
    nextCycle();
    ld_chk_valid = 1'b0;
    checkOutput("ld_done_busy", 32'(busy), 32'd0);

    // reset while two entries are pending
    dm_gnt = 1'b0;
    applyStimulus(1'b1, SW, 32'h300, 32'hAAAA_0000);
    nextCycle();
    applyStimulus(1'b1, SW, 32'h304, 32'hBBBB_0000);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("pre_rst_busy", 32'(busy),     32'd1);
    checkOutput("pre_rst_req",  32'(dm_req),   32'd1);
    checkOutput("pre_rst_rdy",  32'(st_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_ceb",  32'(DM_CEB), 32'd1);
    checkOutput("mid_rst_web",  32'(DM_WEB), 32'hF);
    checkOutput("mid_rst_busy", 32'(busy),   32'd0);
    #1 rst = 1'b0;
    dm_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("post_rst_ceb", 32'(DM_CEB), 32'd1);
      checkOutput("post_rst_web", 32'(DM_WEB), 32'hF);
    end
    checkOutput("post_rst_ready", 32'(st_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_drain_buffer.md
# store_drain_buffer

Write-side counterpart of the MEM/WB load path. Accepts store requests from the MEM stage and formats them into byte lanes. It holds them in a small FIFO and drains them one at a time to the data memory through a request/grant handshake, driving active-low chip enable and byte write enables. It sits between the MEM stage and the data-memory port. It also flags loads that hit a pending store so the hazard unit can stall.

## Interface
- DEPTH, 2, store buffer entries (power of two, ≥2)
- AW, 14, data-memory word address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- st_valid  in  1  store request from MEM stage
- st_type  in  2  01=SB, 10=SH, 11=SW, 00=illegal
- st_addr  in  32  byte address
- st_data  in  32  store data, right-aligned
- st_ready  out  1  buffer can accept; transfer on st_valid&&st_ready
- st_misalign  out  1  one-cycle pulse: request dropped (misaligned/illegal)
- ld_chk_valid  in  1  MEM-stage load present
- ld_chk_addr  in  32  load byte address
- ld_conflict  out  1  load word matches any valid buffered entry
- dm_req  out  1  head entry presented to memory
- dm_gnt  in  1  memory accepts head this cycle
- DM_CEB  out  1  active-low chip enable (= !dm_req)
- DM_WEB  out  4  active-low byte write enables
- DM_A  out  AW  word address (st_addr[AW+1:2])
- DM_DI  out  32  lane-shifted write data
- busy  out  1  buffer non-empty

## Operation
- Formatting (combinational, before enqueue), s=st_addr[1:0]:
  - SB: WEB=~(4'b0001<<s); DI=st_data[7:0]<<(8*s).
  - SH: legal only if s[0]=0; WEB=s[1]?4'b0011:4'b1100; DI=st_data[15:0]<<(16*s[1]).
  - SW: legal only if s=00; WEB=4'b0000; DI=st_data.
  - Unused DI lanes are 0.
- Illegal type or misaligned accepted request: not enqueued, st_misalign=1 next cycle, st_ready unaffected.
- FIFO: write pointer, read pointer, count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
  - st_ready = (count < DEPTH). A same-cycle dequeue does not raise st_ready.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- Drain FSM: IDLE, REQ.
  - IDLE: count=0. dm_req=0, DM_CEB=1, DM_WEB=4'hF, DM_A=0, DM_DI=0.
  - IDLE→REQ when count becomes non-zero.
  - REQ: head entry drives DM_*; dm_req=1. Outputs stay stable until dm_gnt.
  - On dm_gnt: pop. Stay in REQ if entries remain (next head presented the following cycle), else go to IDLE.
  - dm_gnt while in IDLE is ignored.
- ld_conflict = ld_chk_valid && any valid entry with addr[31:2]==ld_chk_addr[31:2]. It is combinational and excludes the incoming store of the same cycle.
- Stores are drained strictly in order. No merging.

## Timing
- Reset values:
  - st_ready=1, st_misalign=0, ld_conflict=0 (if ld_chk_valid=0).
  - dm_req=0, DM_CEB=1, DM_WEB=4'hF, DM_A=0, DM_DI=0, busy=0.
  - Pointers and count are 0; FSM is in IDLE.
- Reset mid-operation discards all entries immediately. No partial write is issued after rst rises.
- Enqueue latency: a store accepted at edge N is presented to memory with dm_req=1 during cycle N+1, when the buffer was empty.
- Throughput: one store per cycle with continuous dm_gnt.
- All outputs except ld_conflict and st_ready come from registers or registered storage (no path from st_* to DM_*).

## Structure
- Shared package cpu_pkg: store-type enum (ST_SB, ST_SH, ST_SW), WEB_NONE=4'hF, and drain state enum (IDLE, REQ).
- Sub-module store_lane_fmt: combinational. Takes type, addr[1:0] and data; outputs WEB, DI and illegal.
- Top level holds the FIFO arrays, pointers, count, FSM and conflict comparators.

## Test plan
- SB addr 0x1003, data 0xAB, dm_gnt=1 → next cycle DM_WEB=4'b0111, DM_DI=0xAB000000, DM_A=0x400, DM_CEB=0; then IDLE.
- SH addr 0x2002, data 0x1234 → DM_WEB=4'b0011, DM_DI=0x12340000. SW addr 0x2002 → st_misalign pulse, nothing written, busy=0.
- dm_gnt=0, three SW stores back-to-back (DEPTH=2) → st_ready low after two. Third held. Raising dm_gnt drains in order with addresses 0x10, 0x14, 0x18.
- Buffer holds SW at 0x100 → load at 0x102 gives ld_conflict=1; load at 0x104 gives 0. After the drain, 0x102 gives 0.
- Full buffer, simultaneous enqueue attempt and dm_gnt → no enqueue, count drops by 1, st_ready=1 next cycle.
- rst asserted while in REQ with 2 entries → DM_CEB=1, DM_WEB=4'hF, busy=0 immediately; no write on the following edges.
